// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM states and PPROT attribute bits.
// Also used by the slave adapter and the formal property harness.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;
    localparam logic [2:0] PPROT_PRIV    = 3'b001;
    localparam logic [2:0] PPROT_NONSEC  = 3'b010;
    localparam logic [2:0] PPROT_INSTR   = 3'b100;

endpackage

// File: rtl/apb_master_bridge.sv
// Native valid/ready command to APB4 master bridge: one SETUP/ACCESS transfer per
// command, with result (prdata, pslverr or timeout) returned on a valid/ready response.
//
// state  | meaning
// IDLE   | cmd_ready=1, waiting for a command
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or timeout
// RESP   | rsp_valid=1 until rsp_ready
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_tmo,

    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;

    apb_state_e                r_state;
    apb_state_e                w_state_nxt;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic                      w_tmo_hit;

    logic [ADDR_WIDTH-1:0]     r_paddr;
    logic [2:0]                r_pprot;
    logic                      r_pwrite;
    logic [DATA_WIDTH-1:0]     r_pwdata;
    logic [STRB_WIDTH-1:0]     r_pstrb;

    logic [DATA_WIDTH-1:0]     r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      r_rsp_tmo;

    // Timeout fires in the ACCESS cycle that would bring the count to TIMEOUT
    assign w_tmo_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (cmd_valid)            w_state_nxt = SETUP;
            SETUP:                             w_state_nxt = ACCESS;
            ACCESS:  if (pready || w_tmo_hit)  w_state_nxt = RESP;
            RESP:    if (rsp_ready)            w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_paddr     <= '0;
            r_pprot     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_paddr  <= cmd_addr;
                        r_pprot  <= cmd_prot;
                        r_pwrite <= cmd_write;
                        r_pwdata <= cmd_wdata;
                        r_pstrb  <= cmd_write ? cmd_strb : '0;
                        r_cnt    <= '0;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_err   <= pslverr;
                        r_rsp_tmo   <= 1'b0;
                    end else begin
                        if (TIMEOUT != 0) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (w_tmo_hit) begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_tmo   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_tmo   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decoded from state so the async reset drops psel/penable without a clock
    assign psel      = (r_state == SETUP) || (r_state == ACCESS);
    assign penable   = (r_state == ACCESS);
    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);

    assign paddr     = r_paddr;
    assign pprot     = r_pprot;
    assign pwrite    = r_pwrite;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign rsp_tmo   = r_rsp_tmo;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=4): zero-wait write, wait-state read,
// slave error with response backpressure, timeout, and asynchronous mid-transfer reset.
module tb_apb_master_bridge;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;

    int n_cmp = 0;
    int n_err = 0;

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb  = '0;   cmd_prot  = '0;   rsp_ready = 1'b0;
        prdata    = '0;   pready    = 1'b0; pslverr   = 1'b0;

        // Reset state
        #2;
        chk("rst_psel",      32'(psel),      32'd0);
        chk("rst_penable",   32'(penable),   32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr",     paddr,          32'h0);
        chk("rst_pstrb",     32'(pstrb),     32'd0);
        #10 presetn = 1'b1;
        tick();

        // 1: zero-wait write
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF;
        cmd_strb = 4'hF; cmd_prot = PPROT_NONSEC; pready = 1'b1; prdata = 32'h11111111;
        chk("w_c0_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("w_c1_psel",      32'(psel),      32'd1);
        chk("w_c1_penable",   32'(penable),   32'd0);
        chk("w_c1_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("w_c1_paddr",     paddr,          32'h10);
        chk("w_c1_pwrite",    32'(pwrite),    32'd1);
        chk("w_c1_pwdata",    pwdata,         32'hDEADBEEF);
        chk("w_c1_pstrb",     32'(pstrb),     32'hF);
        chk("w_c1_pprot",     32'(pprot),     32'd2);
        tick();
        chk("w_c2_psel",      32'(psel),      32'd1);
        chk("w_c2_penable",   32'(penable),   32'd1);
        chk("w_c2_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("w_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w_c3_rsp_err",   32'(rsp_err),   32'd0);
        chk("w_c3_rsp_tmo",   32'(rsp_tmo),   32'd0);
        chk("w_c3_rsp_rdata", rsp_rdata,      32'h0);
        chk("w_c3_psel",      32'(psel),      32'd0);
        chk("w_c3_penable",   32'(penable),   32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w_c4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("w_c4_cmd_ready", 32'(cmd_ready), 32'd1);

        // 2: read with 3 wait states; pready lands in the cycle the timeout would fire
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h04; cmd_strb = 4'hF;
        cmd_prot = PPROT_PRIV; pready = 1'b0; prdata = 32'h5A5A0001;
        tick();
        cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0;
        chk("r_setup_pstrb",  32'(pstrb),  32'd0);
        chk("r_setup_pwrite", 32'(pwrite), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("r_wait_penable", 32'(penable), 32'd1);
            chk("r_wait_paddr",   paddr,        32'h04);
            chk("r_wait_pwrite",  32'(pwrite),  32'd0);
            chk("r_wait_pstrb",   32'(pstrb),   32'd0);
            tick();
        end
        pready = 1'b1;
        chk("r_last_psel",    32'(psel),    32'd1);
        chk("r_last_penable", 32'(penable), 32'd1);
        tick();
        pready = 1'b0;
        chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r_rsp_rdata", rsp_rdata,      32'h5A5A0001);
        chk("r_rsp_err",   32'(rsp_err),   32'd0);
        chk("r_rsp_tmo",   32'(rsp_tmo),   32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 3: read ending in pslverr, then 5 cycles of response backpressure
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h08;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE0000;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        // queued command (timeout read) presented while the response is stalled
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h77777777;
        for (int i = 0; i < 5; i++) begin
            chk("e_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("e_rsp_err",   32'(rsp_err),   32'd1);
            chk("e_rsp_tmo",   32'(rsp_tmo),   32'd0);
            chk("e_rsp_rdata", rsp_rdata,      32'hCAFE0000);
            chk("e_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("e_psel",      32'(psel),      32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("e_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("e_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("e_idle_rsp_err",   32'(rsp_err),   32'd0);

        // 4: pready never arrives, timeout after 4 ACCESS cycles
        tick();
        cmd_valid = 1'b0;
        chk("t_setup_psel",  32'(psel),  32'd1);
        chk("t_setup_paddr", paddr,      32'h30);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t_access_psel",    32'(psel),    32'd1);
            chk("t_access_penable", 32'(penable), 32'd1);
            tick();
        end
        chk("t_psel",      32'(psel),      32'd0);
        chk("t_penable",   32'(penable),   32'd0);
        chk("t_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t_rsp_err",   32'(rsp_err),   32'd1);
        chk("t_rsp_tmo",   32'(rsp_tmo),   32'd1);
        chk("t_rsp_rdata", rsp_rdata,      32'h0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // 6: asynchronous reset in the middle of ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44; cmd_strb = 4'hF;
        pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("a_setup_pstrb", 32'(pstrb), 32'd0);
        tick();
        chk("a_access_penable", 32'(penable), 32'd1);
        chk("a_access_pstrb",   32'(pstrb),   32'd0);
        #2 presetn = 1'b0;
        #1;
        chk("a_rst_psel",      32'(psel),      32'd0);
        chk("a_rst_penable",   32'(penable),   32'd0);
        chk("a_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("a_rst_paddr",     paddr,          32'h0);
        @(negedge pclk);
        presetn = 1'b1;
        tick();
        chk("a_post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("a_post_psel",      32'(psel),      32'd0);
        chk("a_post_rsp_valid", 32'(rsp_valid), 32'd0);

        // zero-wait read after recovery
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50; cmd_strb = 4'hF;
        pready = 1'b1; prdata = 32'h12345678;
        tick();
        cmd_valid = 1'b0;
        chk("z_setup_pstrb", 32'(pstrb), 32'd0);
        chk("z_setup_paddr", paddr,      32'h50);
        tick();
        tick();
        chk("z_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("z_rsp_rdata", rsp_rdata,      32'h12345678);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("z_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("z_idle_rsp_rdata", rsp_rdata,      32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
